// File: rtl/kgp_risc_pkg.sv
// Shared fetch-stage types and constants: XLEN, default PC_STEP/RESET_PC,
// fetch FSM encoding and the {instr, pc} packet moved between fetch storage stages.
package kgp_risc_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    // Modulo-2^XLEN advance; wraps silently at the top of the address space.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc,
                                                input logic [XLEN-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: ROM address/data, execute redirect, decode handshake
// (instr_valid/instr_ready) and the fetch FSM state for observation.
interface instr_fetch_unit_if;
    import kgp_risc_pkg::*;

    // Decode handshake: a word transfers in every cycle where instr_valid && instr_ready;
    // once instr_valid rises, instr_out/pc_out/pc_plus4_out stay stable until that transfer
    // or a redirect, and instr_valid never depends combinationally on instr_ready.
    logic [XLEN-1:0] rom_addr;
    logic [XLEN-1:0] rom_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus4_out;
    logic            instr_valid;
    logic            instr_ready;
    logic            misalign_err;
    fetch_state_e    dbg_state;

    modport master (
        output rom_addr, instr_out, pc_out, pc_plus4_out, instr_valid, misalign_err, dbg_state,
        input  rom_data, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  rom_addr, instr_out, pc_out, pc_plus4_out, instr_valid, misalign_err, dbg_state,
        output rom_data, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/instr_fetch_unit_skid_buf.sv
// One-entry skid buffer for fetch packets; flush wins over push, push wins over pop,
// so a simultaneous push+pop replaces the held packet.
module fetch_skid_buf
    import kgp_risc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  fetch_pkt_t i_pkt,
    output fetch_pkt_t o_pkt,
    output logic       o_full
);

    logic       r_full;
    fetch_pkt_t r_pkt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_pkt  <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_push) begin
            r_full <= 1'b1;
            r_pkt  <= i_pkt;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_pkt  = r_pkt;
    assign o_full = r_full;

endmodule

// File: rtl/instr_fetch_unit.sv
// PC generation and fetch stage in front of a 1-cycle synchronous ROM.
// Optional macro FETCH_PERF_CNT_EN adds a saturating accepted-fetch counter (fetch_count).
module instr_fetch_unit
    import kgp_risc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = kgp_risc_pkg::RESET_PC,
    parameter logic [XLEN-1:0] PC_STEP     = kgp_risc_pkg::PC_STEP,
    parameter int              ROM_LATENCY = 1
) (
    input logic                clka,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count
`endif
);

    if (ROM_LATENCY != 1) begin : g_latency_check
        $error("instr_fetch_unit: only ROM_LATENCY == 1 is supported");
    end

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_rom_addr;
    logic [XLEN-1:0] r_req_pc;
    logic            r_inflight;
    logic            r_misalign;
    logic            r_valid;
    fetch_pkt_t      r_out_pkt;
    logic [XLEN-1:0] r_pc_plus4;

    logic       w_out_free, w_skid_full, w_skid_push, w_skid_pop, w_skid_full_next;
    logic       w_issue, w_load;
    fetch_pkt_t w_rsp_pkt, w_skid_pkt, w_load_pkt;

    // At most one ROM word is ever in flight, so an address is only issued when the
    // skid will be empty next cycle and can absorb that word if decode stalls.
    assign w_out_free       = !r_valid || bus.instr_ready;
    assign w_rsp_pkt        = '{instr: bus.rom_data, pc: r_req_pc};
    assign w_skid_pop       = w_out_free && w_skid_full;
    assign w_skid_push      = r_inflight && !(w_out_free && !w_skid_full);
    assign w_skid_full_next = w_skid_push || (w_skid_full && !w_skid_pop);
    assign w_load           = w_out_free && (w_skid_full || r_inflight);
    assign w_load_pkt       = w_skid_full ? w_skid_pkt : w_rsp_pkt;
    assign w_issue          = (r_state == S_BOOT) || ((r_state == S_RUN) && !w_skid_full_next);

    fetch_skid_buf u_skid (
        .clk     (clka),
        .rst_n   (rst_n),
        .i_push  (w_skid_push),
        .i_pop   (w_skid_pop),
        .i_flush (bus.redirect_valid),
        .i_pkt   (w_rsp_pkt),
        .o_pkt   (w_skid_pkt),
        .o_full  (w_skid_full)
    );

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_rom_addr <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
            r_req_pc   <= r_rom_addr;
            if (bus.redirect_valid) begin
                // The word returning this cycle and this cycle's issue are both abandoned.
                r_state    <= S_RUN;
                r_rom_addr <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_rom_addr <= next_pc(r_rom_addr, PC_STEP);
                end
                case (r_state)
                    S_BOOT:  r_state <= S_RUN;
                    default: r_state <= w_skid_full_next ? S_STALL : S_RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_out_pkt  <= '0;
            r_pc_plus4 <= '0;
        end else if (bus.redirect_valid) begin
            r_valid <= 1'b0;
        end else if (w_out_free) begin
            r_valid <= w_skid_full || r_inflight;
            if (w_load) begin
                r_out_pkt  <= w_load_pkt;
                r_pc_plus4 <= next_pc(w_load_pkt.pc, PC_STEP);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (r_valid && bus.instr_ready && (r_fetch_count != 32'hFFFF_FFFF)) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

    assign bus.rom_addr     = r_rom_addr;
    assign bus.instr_out    = r_out_pkt.instr;
    assign bus.pc_out       = r_out_pkt.pc;
    assign bus.pc_plus4_out = r_pc_plus4;
    assign bus.instr_valid  = r_valid;
    assign bus.misalign_err = r_misalign;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetch/stall/redirect/wrap/reset steps followed by
// random ready/redirect traffic, all checked against an accepted-PC stream model.
module tb_instr_fetch_unit;
    import kgp_risc_pkg::*;

    logic clka = 1'b0;
    logic rst_n;
    instr_fetch_unit_if bus ();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    instr_fetch_unit dut (
        .clka  (clka),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #5 clka = ~clka;

    // ROM content: word[i] = A000_0000 + i, i = byte address / 4.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clka) bus.rom_data <= rom_word(bus.rom_addr);

    int n_cmp  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int exp_cnt = 0;
    logic [31:0] exp_q[$];
    bit          in_reset = 1'b1;
    bit          hold_pending = 1'b0;
    bit          redir_pending = 1'b0;
    logic [31:0] held_pc, held_instr, redir_target;
    logic        redir_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected accepted-PC stream: the next few sequential addresses from the last target.
    task automatic model_restart(input logic [31:0] target);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(target + 32'(4 * i));
    endtask

    task automatic monitor();
        logic [31:0] last;
        if (!in_reset) begin
`ifdef FETCH_PERF_CNT_EN
            check("fetch_count", fetch_count, 32'(exp_cnt));
`endif
            if (hold_pending) begin
                check("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
                check("hold_pc", bus.pc_out, held_pc);
                check("hold_instr", bus.instr_out, held_instr);
            end
            if (redir_pending) begin
                check("redir_valid_low", {31'd0, bus.instr_valid}, 32'd0);
                check("redir_rom_addr", bus.rom_addr, redir_target);
                check("redir_misalign", {31'd0, bus.misalign_err}, {31'd0, redir_mis});
            end else begin
                check("misalign_idle", {31'd0, bus.misalign_err}, 32'd0);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                check("acc_pc", bus.pc_out, exp_q[0]);
                check("acc_instr", bus.instr_out, rom_word(exp_q[0]));
                check("acc_pc4", bus.pc_plus4_out, exp_q[0] + 32'd4);
                last = exp_q[$];
                void'(exp_q.pop_front());
                exp_q.push_back(last + 32'd4);
                exp_cnt++;
                n_acc++;
            end
            hold_pending  = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
            held_pc       = bus.pc_out;
            held_instr    = bus.instr_out;
            redir_pending = bus.redirect_valid;
            if (bus.redirect_valid) begin
                redir_target = {bus.redirect_pc[31:2], 2'b00};
                redir_mis    = (bus.redirect_pc[1:0] != 2'b00);
                model_restart(redir_target);
            end
        end
    endtask

    task automatic step();
        monitor();
        @(posedge clka);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic wait_valid_pc(input logic [31:0] pc, input string tag);
        int k = 0;
        while (!(bus.instr_valid === 1'b1 && bus.pc_out === pc) && k < 40) begin
            step();
            k++;
        end
        check(tag, bus.pc_out, pc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_addr"}, bus.rom_addr, 32'h0);
        check({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
        check({tag, "_instr"}, bus.instr_out, 32'h0);
        check({tag, "_pc"}, bus.pc_out, 32'h0);
        check({tag, "_pc4"}, bus.pc_plus4_out, 32'h0);
        check({tag, "_misalign"}, {31'd0, bus.misalign_err}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check({tag, "_fetch_count"}, fetch_count, 32'h0);
`endif
    endtask

    initial begin
        int acc_before;
        rst_n              = 1'b0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (3) @(posedge clka);
        #1;
        check_reset_outputs("reset");
        check("reset_state", 32'(bus.dbg_state), 32'(S_BOOT));

        // Boot and sequential fetch.
        rst_n = 1'b1;
        in_reset = 1'b0;
        model_restart(32'h0);
        check("boot_rom_addr", bus.rom_addr, 32'h0);
        step();
        check("c1_rom_addr", bus.rom_addr, 32'h4);
        check("c1_valid", {31'd0, bus.instr_valid}, 32'd0);
        step();
        check("c2_rom_addr", bus.rom_addr, 32'h8);
        check("c2_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("c2_pc", bus.pc_out, 32'h0);
        step();
        check("c3_rom_addr", bus.rom_addr, 32'hC);
        check("c3_pc", bus.pc_out, 32'h4);
        step();

        // Stall three cycles at pc 8.
        check("stall_pc", bus.pc_out, 32'h8);
        bus.instr_ready = 1'b0;
        check("stall_rom_addr0", bus.rom_addr, 32'h10);
        step();
        check("stall_rom_addr1", bus.rom_addr, 32'h10);
        check("stall_state", 32'(bus.dbg_state), 32'(S_STALL));
        step();
        check("stall_rom_addr2", bus.rom_addr, 32'h10);
        step();
        bus.instr_ready = 1'b1;
        check("resume_rom_addr", bus.rom_addr, 32'h10);
        check("resume_pc8", bus.pc_out, 32'h8);
        step();
        check("resume_pc12", bus.pc_out, 32'hC);
        check("resume_valid12", {31'd0, bus.instr_valid}, 32'd1);
        step();
        wait_valid_pc(32'h10, "resume_pc16");

        // Redirect to 0x40 while pc 4 is presented.
        do_redirect(32'h0);
        wait_valid_pc(32'h4, "reach_pc4");
        do_redirect(32'h40);
        check("r40_valid1", {31'd0, bus.instr_valid}, 32'd0);
        check("r40_rom_addr", bus.rom_addr, 32'h40);
        step();
        check("r40_valid2", {31'd0, bus.instr_valid}, 32'd0);
        step();
        check("r40_valid3", {31'd0, bus.instr_valid}, 32'd1);
        check("r40_pc", bus.pc_out, 32'h40);
        check("r40_instr", bus.instr_out, 32'hA000_0010);

        // Misaligned redirect.
        do_redirect(32'h42);
        check("r42_misalign", {31'd0, bus.misalign_err}, 32'd1);
        check("r42_rom_addr", bus.rom_addr, 32'h40);
        step();
        check("r42_misalign_off", {31'd0, bus.misalign_err}, 32'd0);
        wait_valid_pc(32'h40, "r42_pc");

        // Address wrap.
        do_redirect(32'hFFFF_FFFC);
        wait_valid_pc(32'hFFFF_FFFC, "wrap_pc");
        check("wrap_pc4", bus.pc_plus4_out, 32'h0);
        step();
        check("wrap_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("wrap_next_pc", bus.pc_out, 32'h0);

        // Reset in the middle of a stall with the skid full.
        bus.instr_ready = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        in_reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clka);
        #1;
        rst_n = 1'b1;
        bus.instr_ready = 1'b1;
        hold_pending = 1'b0;
        redir_pending = 1'b0;
        exp_cnt = 0;
        in_reset = 1'b0;
        model_restart(32'h0);
        check("restart_rom_addr", bus.rom_addr, 32'h0);
        step();
        step();
        check("restart_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("restart_pc", bus.pc_out, 32'h0);

        // Random ready and redirect traffic.
        acc_before = n_acc;
        for (int i = 0; i < 600; i++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc = ($urandom_range(0, 3) == 0) ?
                                  (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            end
            step();
            bus.redirect_valid = 1'b0;
        end
        bus.instr_ready = 1'b1;
        repeat (4) step();
        check("rand_progress", {31'd0, (n_acc - acc_before) >= 100}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-counter and fetch stage that sits directly upstream of Instruction_Rom.
- Drives the ROM byte address (addra) and captures the instruction word (douta), which arrives one clka cycle later (synchronous-read ROM).
- Presents {instruction, PC} to the decode stage over a valid/ready handshake.
- Accepts branch/jump redirects from execute and holds cleanly under downstream stall.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- PC_STEP, 4, byte increment per sequential fetch.
- ROM_LATENCY, 1, ROM read latency in cycles; only value 1 is supported, and elaboration errors otherwise.

Ports:
- clka  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rom_addr  out  32  byte address to Instruction_Rom addra.
- rom_data  in  32  Instruction_Rom douta, valid one cycle after rom_addr.
- redirect_valid  in  1  one-cycle pulse: branch/jump taken.
- redirect_pc  in  32  redirect target byte address.
- instr_out  out  32  instruction to decode.
- pc_out  out  32  byte address of instr_out.
- pc_plus4_out  out  32  pc_out + PC_STEP, for link registers.
- instr_valid  out  1  instr_out/pc_out are valid.
- instr_ready  in  1  decode accepts when instr_valid && instr_ready.
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset (async assert, sync deassert by the user):
  - rom_addr = RESET_PC; instr_valid = 0; instr_out = 0; pc_out = 0; pc_plus4_out = 0; misalign_err = 0.
  - FSM = S_BOOT; skid buffer empty; in-flight flag cleared.
- FSM states:
  - S_BOOT: issue RESET_PC for one cycle -> S_RUN.
  - S_RUN: issue rom_addr each cycle; rom_addr += PC_STEP when the issued word will be accepted or buffered. Output stalled and skid full -> S_STALL.
  - S_STALL: rom_addr held; no new issue counted. Skid drains -> S_RUN.
  - redirect_valid in any state -> S_RUN.
- Latency: address issued in cycle t -> instr_valid with that word in cycle t+2 (ROM at t+1, output register at t+2). Steady state is 1 instruction/cycle with instr_ready held high.
- In-flight tracking: req_pc registers the issued address; rom_data is qualified by a registered inflight bit and tagged with req_pc.
- Stall handling:
  - When instr_valid && !instr_ready, the output register holds (instr_out, pc_out, pc_plus4_out unchanged).
  - The returning ROM word goes into a 1-entry skid buffer; issue stops.
  - On the next handshake, the skid content moves to the output first.
  - No word is ever dropped or duplicated.
- Redirect (highest priority):
  - In the redirect cycle: instr_valid deasserts next cycle; skid cleared; in-flight response discarded.
  - rom_addr = {redirect_pc[31:2], 2'b00} on the following cycle.
  - First redirected instruction appears 2 cycles after that issue.
  - Redirect beats a simultaneous handshake: the handshake still completes for the current word, but nothing older follows it.
- Misaligned redirect: low bits forced to 0; misalign_err pulses for exactly one cycle.
- Arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Reset mid-operation: all state returns to reset values immediately; in-flight ROM data is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count[31:0], reset 0.
  - Increments once per accepted handshake (instr_valid && instr_ready).
  - Saturates at 32'hFFFF_FFFF; unaffected by redirect.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package kgp_risc_pkg:
  - XLEN = 32, PC_STEP, RESET_PC.
  - Fetch FSM enum {S_BOOT, S_RUN, S_STALL}.
  - Struct fetch_pkt_t {instr, pc}.
- Sub-module fetch_skid_buf: 1-entry buffer holding fetch_pkt_t with push/pop/flush/full.

Test Plan:
- Reset release, instr_ready=1, ROM preloaded with word[i] = 32'hA000_0000 + i:
  - rom_addr sequence 0,4,8,12.
  - instr_valid first high 2 cycles after S_BOOT issue.
  - pc_out 0,4,8 paired with A000_0000, A000_0001, A000_0002.
- Drop instr_ready for 3 cycles while at pc_out=8:
  - pc_out stays 8; skid holds pc 12; rom_addr frozen.
  - On resume, pc_out sequence 8,12,16 with no gaps or repeats.
- redirect_valid with redirect_pc=32'h40 while pc_out=4:
  - Next instr_valid=0; rom_addr=0x40.
  - Next valid pc_out = 0x40 with word[16]; pc 8 is never presented.
- redirect_pc=32'h42:
  - misalign_err pulses 1 cycle; fetch resumes at 0x40.
- Redirect to 32'hFFFF_FFFC: pc_out FFFF_FFFC then 0000_0000; pc_plus4_out for FFFF_FFFC = 0.
- Assert rst_n low mid-stall, with skid full: all outputs return to reset values asynchronously; after release, the sequence restarts at RESET_PC. With FETCH_PERF_CNT_EN defined, fetch_count = 0.
